// File: rtl/rr_decoder_arbiter_if.sv
// Handshake bundle between requesters and the round-robin decoder arbiter.
//   req           : level request per requester (requester -> arbiter)
//   release_i     : owner done, single-cycle pulse (requester -> arbiter)
//   gnt_en        : decoder enable (arbiter -> decoder)
//   gnt_idx       : decoder select, current/last owner (arbiter -> decoder)
//   gnt_onehot    : one-hot form of gnt_idx while gnt_en=1, else zero
//   lease_expired : one-cycle pulse when a grant is revoked by lease
// master = requester side, slave = arbiter side.
interface rr_decoder_arbiter_if #(
  parameter int N_REQ = 8,
  parameter int IDX_W = $clog2(N_REQ)
);
  logic [N_REQ-1:0] req;
  logic             release_i;
  logic             gnt_en;
  logic [IDX_W-1:0] gnt_idx;
  logic [N_REQ-1:0] gnt_onehot;
  logic             lease_expired;

  modport master (
    output req, release_i,
    input  gnt_en, gnt_idx, gnt_onehot, lease_expired
  );

  modport slave (
    input  req, release_i,
    output gnt_en, gnt_idx, gnt_onehot, lease_expired
  );
endinterface

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter sharing one decoder-driven resource among N_REQ
// requesters. Holds a grant until the owner releases, drops its request,
// or its lease runs out while someone else waits; one dead cycle between
// owners (break-before-make). All outputs are registered.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of rr_decoder_arbiter_if (req/release_i in,
//           gnt_en/gnt_idx/gnt_onehot/lease_expired out)
//
// state | meaning
// IDLE  | no owner, waiting for any request
// GRANT | owner gnt_idx drives the decoder, lease counting
// GAP   | one dead cycle after an owner leaves, re-arbitrate
module rr_decoder_arbiter #(
  parameter int N_REQ        = 8,
  parameter int IDX_W        = $clog2(N_REQ),
  parameter int LEASE_CYCLES = 4
) (
  input logic             clk,
  input logic             rst_n,
  rr_decoder_arbiter_if.slave bus
);

  localparam int CNT_W = ($clog2(LEASE_CYCLES + 1) < 1) ? 1 : $clog2(LEASE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] lease_cnt;

  logic [IDX_W-1:0] winner;
  logic [IDX_W:0]   cand_sum;
  logic             found;
  logic             any_req;
  logic             others_req;
  logic             owner_drop;
  logic             lease_hit;
  logic             exit_grant;
  logic [IDX_W-1:0] ptr_next;
  logic             lease_sat;

  // Search ptr, ptr+1, ... wrapping at N_REQ; first requester wins.
  always_comb begin
    winner   = ptr;
    found    = 1'b0;
    cand_sum = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand_sum >= (IDX_W+1)'(N_REQ))
        cand_sum = cand_sum - (IDX_W+1)'(N_REQ);
      if (!found && bus.req[cand_sum[IDX_W-1:0]]) begin
        winner = cand_sum[IDX_W-1:0];
        found  = 1'b1;
      end
    end
  end

  assign any_req    = |bus.req;
  // gnt_onehot is the owner mask while in GRANT
  assign others_req = |(bus.req & ~bus.gnt_onehot);
  assign owner_drop = ~bus.req[bus.gnt_idx];
  assign lease_sat  = (LEASE_CYCLES != 0) && (lease_cnt == CNT_W'(LEASE_CYCLES));
  assign lease_hit  = lease_sat && others_req;
  assign exit_grant = bus.release_i || owner_drop || lease_hit;
  assign ptr_next   = (bus.gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : bus.gnt_idx + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      ptr               <= '0;
      lease_cnt         <= '0;
      bus.gnt_en        <= 1'b0;
      bus.gnt_idx       <= '0;
      bus.gnt_onehot    <= '0;
      bus.lease_expired <= 1'b0;
    end else begin
      bus.lease_expired <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (any_req) begin
            state          <= GRANT;
            bus.gnt_idx    <= winner;
            bus.gnt_onehot <= {{(N_REQ-1){1'b0}}, 1'b1} << winner;
            bus.gnt_en     <= 1'b1;
            lease_cnt      <= CNT_W'(1);
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (exit_grant) begin
            state             <= GAP;
            bus.gnt_en        <= 1'b0;
            bus.gnt_onehot    <= '0;
            ptr               <= ptr_next;
            // release/drop take priority over revocation
            bus.lease_expired <= lease_hit && !bus.release_i && !owner_drop;
          end else if (LEASE_CYCLES != 0 && !lease_sat) begin
            lease_cnt <= lease_cnt + CNT_W'(1);
          end
        end
        default: begin
          state          <= IDLE;
          bus.gnt_en     <= 1'b0;
          bus.gnt_onehot <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/rr_decoder_arbiter.md
Name: rr_decoder_arbiter

Overview:
- Round-robin arbiter that shares one decoder-driven resource (e.g. one-hot select or enable lines) among N_REQ requesters.
- Picks a winner, drives its index plus an enable into the decoder, and holds the grant until the owner releases or its lease expires.
- Enforces break-before-make: one dead cycle between owners.
- Sits between requester logic and the decoder's in/enable inputs.

Parameters:
- N_REQ, 8, number of requesters (2..16); 8 matches a 3-bit decoder.
- IDX_W, $clog2(N_REQ), width of the grant index.
- LEASE_CYCLES, 4, maximum grant length when another requester waits; 0 disables lease enforcement.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  N_REQ  level request per requester; held while the requester wants the resource.
- release_i  input  1  owner done; single-cycle pulse, honoured only in GRANT.
- gnt_en  output  1  drives the decoder enable; 1 only in GRANT.
- gnt_idx  output  IDX_W  drives the decoder select; index of the current/last owner; always < N_REQ.
- gnt_onehot  output  N_REQ  equals 1<<gnt_idx when gnt_en=1, else all zeros.
- lease_expired  output  1  one-cycle pulse when a grant is revoked by lease.

Behaviour:
- Reset (asynchronous, immediate, also mid-grant):
  - state=IDLE, gnt_en=0, gnt_idx=0, gnt_onehot=0, lease_expired=0, ptr=0, lease_cnt=0.
- All outputs are registered.
- Arbitration function:
  - Winner = first i with req[i]=1, searching ptr, ptr+1, ..., N_REQ-1, 0, ..., ptr-1.
  - ptr always lies in 0..N_REQ-1.
- States:
  - IDLE: gnt_en=0.
    - If |req: gnt_idx<=winner, lease_cnt<=1, ->GRANT.
    - Latency: req high at edge k gives gnt_en=1 after edge k+1.
  - GRANT: gnt_en=1, gnt_onehot=1<<gnt_idx, lease_cnt increments and saturates at LEASE_CYCLES.
    - Exit to GAP when any one of:
      - (a) release_i=1
      - (b) req[gnt_idx]=0
      - (c) LEASE_CYCLES!=0, lease_cnt==LEASE_CYCLES, and any req[j]=1 for j!=gnt_idx
    - On exit: ptr <= (gnt_idx+1) mod N_REQ, wrapping N_REQ-1 -> 0.
    - lease_expired=1 for the GAP cycle only if (c) holds and neither (a) nor (b) does.
    - Lease reached with no other requester: owner keeps the grant indefinitely; lease_cnt stays saturated.
  - GAP: gnt_en=0, gnt_onehot=0; exactly one cycle. gnt_idx holds the previous owner during this cycle.
    - If |req: gnt_idx<=winner (using the updated ptr), lease_cnt<=1, ->GRANT.
    - Else ->IDLE.
- Simultaneous events:
  - release_i together with lease condition: treated as release; no lease_expired pulse.
  - release_i outside GRANT: ignored.
  - req changes during GAP: sampled at the GAP edge.
- A revoked owner still requesting is re-granted only after every other pending requester has been served once (fairness via ptr).
- Handoff between owners always shows exactly one cycle with gnt_en=0.

Test Plan (N_REQ=8, LEASE_CYCLES=4):
- Reset then req=0 for 10 cycles -> gnt_en=0, gnt_onehot=0, gnt_idx=0 throughout.
- req=8'h08 from cycle 0 -> gnt_en=1, gnt_idx=3, gnt_onehot=8'h08 from cycle 1; release_i pulse at cycle 3 with req dropped -> gnt_en=0 at cycle 4, state IDLE.
- req=8'hFF held, release after 2 grant cycles each -> grant order 0,1,2,...,7,0 (wrap); one gnt_en=0 cycle between owners.
- req=8'h06 held, no release -> idx1 held 4 cycles, lease_expired=1 in GAP, idx2 granted 4 cycles, then idx1 again.
- req=8'h01 alone held 20 cycles -> grant never revoked, lease_expired stays 0.
- rst_n low mid-grant (idx5) -> gnt_en, gnt_onehot, gnt_idx go to 0 before the next clk edge; after release with req=8'h20, idx5 granted 1 cycle later.
